io_edge_monitor: RTL

- Consumer end of the pin-sampling path: takes the synchronized pin level produced by the tristate pin controller's input stage.
- Measures activity on that level between software-controlled start/stop points: rising/falling edge counts, high/low cycle counts, and min/max complete high-pulse width.
- One instance per monitored pin; outputs feed the register/readback layer.

---
 rtl/io_pkg.sv | 22 ++
 rtl/sat_counter.sv | 36 +++
 rtl/io_edge_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
//   Shared definitions for the pin I/O monitoring path.
//   - State encoding for the edge monitor FSM.
//   - Helper producing the all-ones "no pulse yet" sentinel for a counter width.
// -----------------------------------------------------------------------------
package io_pkg;

  // Monitor FSM state encoding.
  localparam logic STATE_IDLE   = 1'b0;
  localparam logic STATE_ACTIVE = 1'b1;

  // All-ones value for a counter of width cw (cw up to 64). Callers cast the
  // result to their own width.
  function automatic logic [63:0] min_sentinel(input int unsigned cw);
    if (cw >= 64) begin
      return {64{1'b1}};
    end
    return (64'd1 << cw) - 64'd1;
  endfunction

endpackage : io_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   CW-bit up counter that sticks at all-ones instead of wrapping.
//   clr zeroes the count; clr together with inc restarts the count at 1, which
//   lets a length counter count the current cycle when a new run begins.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset, count -> 0
//   clr    in   zero the count (restart at 1 if inc is also set)
//   inc    in   add one, unless already saturated
//   count  out  CW-bit count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CW'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

endmodule : sat_counter

// File: rtl/io_edge_monitor.sv
// -----------------------------------------------------------------------------
// io_edge_monitor
//   Activity monitor for one synchronized pin level. Between software start and
//   stop pulses it counts rising/falling edges, high/low cycles, and tracks the
//   shortest and longest complete high pulse. Statistics accumulate across
//   monitoring windows until clear or reset.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   in           in   synchronized pin level (already double-flopped upstream)
//   start        in   single-cycle pulse, begin monitoring
//   stop         in   single-cycle pulse, end monitoring (wins over start)
//   clear        in   single-cycle pulse, zero all statistics, state kept
//   active       out  1 while monitoring
//   rise_count   out  rising edges seen while active
//   fall_count   out  falling edges seen while active
//   high_cycles  out  active cycles with in==1
//   low_cycles   out  active cycles with in==0
//   min_pulse    out  shortest complete high pulse, all-ones if none
//   max_pulse    out  longest complete high pulse, 0 if none
// All counters saturate at all-ones.
// -----------------------------------------------------------------------------
module io_edge_monitor
  import io_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  output logic          active,
  output logic [CW-1:0] rise_count,
  output logic [CW-1:0] fall_count,
  output logic [CW-1:0] high_cycles,
  output logic [CW-1:0] low_cycles,
  output logic [CW-1:0] min_pulse,
  output logic [CW-1:0] max_pulse
);

  localparam logic [CW-1:0] MIN_SENT = CW'(min_sentinel(CW));

  logic          state;
  logic          state_next;
  logic          prev;
  logic          rise;
  logic          fall;
  logic          count_en;
  logic          pulse_valid;
  logic [CW-1:0] pulse_len;

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  // NOTE: prev deliberately has no reset branch; it tracks in even while rst
  // is high, so the first cycle after reset never sees a false edge.
  always_ff @(posedge clk) begin
    prev <= in;
  end

  assign rise = in & ~prev;
  assign fall = ~in & prev;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STATE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // clear outranks stop/start and leaves the state alone; stop beats start.
  // NOTE: state_next gets a default before any branch so no latch is inferred.
  always_comb begin
    state_next = state;
    if (!clear) begin
      if (state == STATE_IDLE) begin
        if (start && !stop) begin
          state_next = STATE_ACTIVE;
        end
      end else if (stop) begin
        state_next = STATE_IDLE;
      end
    end
  end

  always_comb begin
    active = (state == STATE_ACTIVE);
  end

  // A cycle is measured when the FSM is already active at the edge; the clear
  // cycle's sample is dropped.
  assign count_en = (state == STATE_ACTIVE) && !clear;

  // ---------------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------------
  sat_counter #(.CW(CW)) u_rise_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (count_en && rise),
    .count (rise_count)
  );

  sat_counter #(.CW(CW)) u_fall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (count_en && fall),
    .count (fall_count)
  );

  sat_counter #(.CW(CW)) u_high_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (count_en && in),
    .count (high_cycles)
  );

  sat_counter #(.CW(CW)) u_low_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (count_en && !in),
    .count (low_cycles)
  );

  // ---------------------------------------------------------------------------
  // High-pulse measurement
  // ---------------------------------------------------------------------------
  // A rise restarts the length at 1 (clr+inc); each further high cycle of a
  // tracked pulse adds one. The length is only meaningful while pulse_valid.
  sat_counter #(.CW(CW)) u_pulse_len (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear || (count_en && rise)),
    .inc   (count_en && (rise || (pulse_valid && in))),
    .count (pulse_len)
  );

  // Only pulses whose rise was seen inside a window are tracked; stop drops
  // any pulse still in flight.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pulse_valid <= 1'b0;
    end else if (count_en) begin
      if (stop) begin
        pulse_valid <= 1'b0;
      end else if (rise) begin
        pulse_valid <= 1'b1;
      end else if (fall) begin
        pulse_valid <= 1'b0;
      end
    end
  end

  // A fall on a tracked pulse completes it; pulse_len holds its high length.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      min_pulse <= MIN_SENT;
      max_pulse <= '0;
    end else if (count_en && fall && pulse_valid) begin
      if (pulse_len < min_pulse) begin
        min_pulse <= pulse_len;
      end
      if (pulse_len > max_pulse) begin
        max_pulse <= pulse_len;
      end
    end
  end

endmodule : io_edge_monitor
